// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction-memory port and the IF/ID register.
// Handles decode stall (with a one-entry hold buffer), redirect flush and variable memory latency.
module fetch_unit #(
    parameter int unsigned            WIDTH    = 32,
    parameter logic [WIDTH-1:0]       RESET_PC = '0,
    parameter int unsigned            PC_STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr_d,
    output logic [WIDTH-1:0] pc_d,
    output logic [WIDTH-1:0] pcplus_d,
    output logic             valid_d
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DISCARD} state_t;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    state_t           state, state_n;
    logic [WIDTH-1:0] pc, pc_n, fa, fa_n;
    logic [WIDTH-1:0] hb_instr, hb_instr_n, hb_pc, hb_pc_n;
    logic [WIDTH-1:0] instr_n, pcd_n, pcp_n;
    logic             vld_n, accept;

    assign accept    = !stall || !valid_d;
    assign imem_req  = (state == S_WAIT) || (state == S_DISCARD);
    assign imem_addr = fa;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            fa       <= RESET_PC;
            hb_instr <= '0;
            hb_pc    <= '0;
            instr_d  <= '0;
            pc_d     <= '0;
            pcplus_d <= '0;
            valid_d  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            fa       <= fa_n;
            hb_instr <= hb_instr_n;
            hb_pc    <= hb_pc_n;
            instr_d  <= instr_n;
            pc_d     <= pcd_n;
            pcplus_d <= pcp_n;
            valid_d  <= vld_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        fa_n       = fa;
        hb_instr_n = hb_instr;
        hb_pc_n    = hb_pc;
        instr_n    = instr_d;
        pcd_n      = pc_d;
        pcp_n      = pcplus_d;
        vld_n      = valid_d;

        if (redirect) begin
            // Flush wins over stall and ack; an un-acked request must still drain before refetch.
            vld_n = 1'b0;
            pc_n  = redirect_pc;
            if ((state == S_WAIT || state == S_DISCARD) && !imem_ack) begin
                state_n = S_DISCARD;
            end else begin
                state_n = S_WAIT;
                fa_n    = redirect_pc;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_WAIT;
                    fa_n    = pc;
                end
                S_WAIT: begin
                    if (imem_ack && accept) begin
                        instr_n = imem_rdata;
                        pcd_n   = fa;
                        pcp_n   = fa + STEP;
                        vld_n   = 1'b1;
                        fa_n    = fa + STEP;
                    end else if (imem_ack) begin
                        hb_instr_n = imem_rdata;
                        hb_pc_n    = fa;
                        state_n    = S_HOLD;
                    end else if (accept) begin
                        vld_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_n = hb_instr;
                        pcd_n   = hb_pc;
                        pcp_n   = hb_pc + STEP;
                        vld_n   = 1'b1;
                        fa_n    = hb_pc + STEP;
                        state_n = S_WAIT;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        fa_n    = pc;
                        state_n = S_WAIT;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming/stall/redirect plus hand sequences
// for async reset mid-request and PC wrap with a high RESET_PC.
module tb_fetch_unit;

    localparam logic [31:0] XORK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, rst1_n = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0, ack = 1'b1;
    logic [31:0] rpc = '0;
    logic        req, valid;
    logic [31:0] addr, rdata, instr, pcd, pcp;
    logic        req1, valid1;
    logic [31:0] addr1, rdata1, instr1, pcd1, pcp1;

    int nvec = 0, nmis = 0;

    always #5 clk = ~clk;

    assign rdata  = addr ^ XORK;
    assign rdata1 = addr1 ^ XORK;

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .reset(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(rpc),
        .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
        .instr_d(instr), .pc_d(pcd), .pcplus_d(pcp), .valid_d(valid));

    fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .clk(clk), .reset(rst1_n), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(req1), .imem_addr(addr1), .imem_ack(1'b1), .imem_rdata(rdata1),
        .instr_d(instr1), .pc_d(pcd1), .pcplus_d(pcp1), .valid_d(valid1));

    typedef struct {
        logic        stall, redirect, ack;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic s, logic r, logic a, logic [31:0] rp,
                                logic ev, logic [31:0] ep, logic eq, logic [31:0] ea);
        vec_t v;
        v.stall = s; v.redirect = r; v.ack = a; v.rpc = rp;
        v.e_valid = ev; v.e_pc = ep; v.e_req = eq; v.e_addr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          stall redir ack rpc        valid pc         req  addr
        tbl[0]  = mk(0, 0, 1, 32'h0,   0, 32'h0,   1, 32'h0);   // IDLE -> WAIT
        tbl[1]  = mk(0, 0, 1, 32'h0,   1, 32'h0,   1, 32'h4);
        tbl[2]  = mk(0, 0, 1, 32'h0,   1, 32'h4,   1, 32'h8);
        tbl[3]  = mk(0, 0, 1, 32'h0,   1, 32'h8,   1, 32'hC);
        tbl[4]  = mk(1, 0, 1, 32'h0,   1, 32'h8,   0, 32'hC);   // 0xC captured into HOLD
        tbl[5]  = mk(1, 0, 0, 32'h0,   1, 32'h8,   0, 32'hC);
        tbl[6]  = mk(1, 0, 0, 32'h0,   1, 32'h8,   0, 32'hC);
        tbl[7]  = mk(0, 0, 0, 32'h0,   1, 32'hC,   1, 32'h10);
        tbl[8]  = mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h10);  // latency-3 request
        tbl[9]  = mk(0, 1, 0, 32'h100, 0, 32'h0,   1, 32'h10);  // redirect -> DISCARD
        tbl[10] = mk(0, 0, 1, 32'h0,   0, 32'h0,   1, 32'h100); // stale ack dropped
        tbl[11] = mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h100);
        tbl[12] = mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h100);
        tbl[13] = mk(0, 0, 1, 32'h0,   1, 32'h100, 1, 32'h104);
        tbl[14] = mk(0, 0, 1, 32'h0,   1, 32'h104, 1, 32'h108);
        tbl[15] = mk(1, 0, 1, 32'h0,   1, 32'h104, 0, 32'h108); // 0x108 held
        tbl[16] = mk(1, 1, 0, 32'h40,  0, 32'h0,   1, 32'h40);  // redirect in HOLD
        tbl[17] = mk(1, 0, 1, 32'h0,   1, 32'h40,  1, 32'h44);  // bubble overwritten despite stall
        tbl[18] = mk(0, 0, 1, 32'h0,   1, 32'h44,  1, 32'h48);
        tbl[19] = mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h48);

        repeat (2) @(posedge clk);
        #1;
        chk("rst valid", 32'(valid), 32'h0);
        chk("rst req",   32'(req),   32'h0);
        chk("rst addr",  addr,       32'h0);
        chk("rst instr", instr,      32'h0);
        chk("rst pc_d",  pcd,        32'h0);
        chk("rst pcplus", pcp,       32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stall = tbl[i].stall; redirect = tbl[i].redirect;
            ack = tbl[i].ack;     rpc = tbl[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), 32'(valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d req", i),   32'(req),   32'(tbl[i].e_req));
            chk($sformatf("v%0d addr", i),  addr,       tbl[i].e_addr);
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d pc_d", i),   pcd,   tbl[i].e_pc);
                chk($sformatf("v%0d instr", i),  instr, tbl[i].e_pc ^ XORK);
                chk($sformatf("v%0d pcplus", i), pcp,   tbl[i].e_pc + 32'd4);
            end
            @(negedge clk);
        end
        stall = 1'b0; redirect = 1'b0;

        // Async reset while a request is outstanding, with a stale ack still asserted.
        ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async valid", 32'(valid), 32'h0);
        chk("async req",   32'(req),   32'h0);
        chk("async addr",  addr,       32'h0);
        chk("async pc_d",  pcd,        32'h0);
        chk("async instr", instr,      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel1 valid", 32'(valid), 32'h0);
        chk("rel1 req",   32'(req),   32'h1);
        chk("rel1 addr",  addr,       32'h0);
        @(posedge clk); #1;
        chk("rel2 valid", 32'(valid), 32'h1);
        chk("rel2 pc_d",  pcd,        32'h0);
        chk("rel2 instr", instr,      32'hA5A5_0000);

        // PC wrap from RESET_PC = 0xFFFF_FFFC.
        @(negedge clk);
        rst1_n = 1'b1;
        @(posedge clk); #1;
        chk("wrap addr0",  addr1,        32'hFFFF_FFFC);
        chk("wrap valid0", 32'(valid1),  32'h0);
        @(posedge clk); #1;
        chk("wrap valid1", 32'(valid1),  32'h1);
        chk("wrap pc1",    pcd1,         32'hFFFF_FFFC);
        chk("wrap pcp1",   pcp1,         32'h0);
        chk("wrap instr1", instr1,       32'h5A5A_FFFC);
        @(posedge clk); #1;
        chk("wrap pc2",    pcd1,         32'h0);
        chk("wrap pcp2",   pcp1,         32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
